player_id_enroller: RTL

Enrolls a new 4-digit player ID into the shared player-ID table, the writable RAM that the ID authentication block scans. It collects four BCD/hex digits from the same switch/button pair used at login. It then scans the table for a duplicate and for the 0xFFFF end-of-table sentinel, and appends the new ID while moving the sentinel down one slot. It sits beside the authentication block on the RAM's second port and is active only while the admin/enroll mode is selected.

---
 rtl/player_id_enroller.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/player_id_enroller.sv
// player_id_enroller
//   Collects a 4-digit player ID from the digit switches/button, scans the
//   shared player-ID table (second RAM port) for a duplicate and for the
//   0xFFFF end-of-table sentinel, then appends the ID. The new sentinel is
//   written one slot down first, so a concurrent reader never runs past the
//   end of the table.
//
//   Optional build macro: ENROLL_VERIFY_EN -- re-reads slot+1 and slot after
//   both writes; any mismatch reports err_code 3 instead of success.
//
// Parameters
//   ADDR_W    table address width (depth = 2**ADDR_W)
//   READ_LAT  RAM read latency in cycles (>= 1)
// Ports
//   clk, rst            clock; synchronous active-low reset
//   enroll_req          start enrollment (IDLE only)
//   abort               cancel while digits are being entered
//   digit_in, digit_btn digit switches and single-cycle enter strobe
//   ram_rdata           table read data
//   ram_addr/wdata/we   registered table address, write data, write enable
//   busy                high whenever not idle
//   enroll_ok/err       one-cycle result pulses
//   err_code            0 dup, 1 reserved, 2 full, 3 corrupt/verify fail
//   new_player_addr     slot written by the last successful enrollment
module player_id_enroller #(
  parameter int ADDR_W   = 5,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enroll_req,
  input  logic              abort,
  input  logic [3:0]        digit_in,
  input  logic              digit_btn,
  input  logic [15:0]       ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic              ram_we,
  output logic              busy,
  output logic              enroll_ok,
  output logic              enroll_err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] new_player_addr
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(READ_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [15:0]       SENTINEL  = 16'hFFFF;
  localparam logic [15:0]       GUEST_ID  = 16'h8888;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DIGIT1,
    S_DIGIT2,
    S_DIGIT3,
    S_DIGIT4,
    S_CAPT,
    S_WAIT,
    S_CHECK,
    S_WRITE_END,
    S_WRITE_ID,
`ifdef ENROLL_VERIFY_EN
    S_VWAIT_END,
    S_VCHK_END,
    S_VWAIT_ID,
    S_VCHK_ID,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state, stateNext;
  logic [15:0]         playerId, playerIdNext;
  logic [CNT_W-1:0]    cnt, cntNext;
  logic [ADDR_W-1:0]   slot, slotNext;
  logic [ADDR_W-1:0]   addrNext, npaNext;
  logic [15:0]         wdataNext;
  logic                weNext, okNext, errNext;
  logic [1:0]          codeNext;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= S_IDLE;
      playerId        <= '0;
      cnt             <= '0;
      slot            <= '0;
      ram_addr        <= '0;
      ram_wdata       <= '0;
      ram_we          <= 1'b0;
      enroll_ok       <= 1'b0;
      enroll_err      <= 1'b0;
      err_code        <= '0;
      new_player_addr <= '0;
    end else begin
      state           <= stateNext;
      playerId        <= playerIdNext;
      cnt             <= cntNext;
      slot            <= slotNext;
      ram_addr        <= addrNext;
      ram_wdata       <= wdataNext;
      ram_we          <= weNext;
      enroll_ok       <= okNext;
      enroll_err      <= errNext;
      err_code        <= codeNext;
      new_player_addr <= npaNext;
    end
  end

  // Registered outputs are computed for the state being entered, so each
  // pulse and write strobe lines up with its own state cycle.
  always_comb begin
    stateNext    = state;
    playerIdNext = playerId;
    cntNext      = cnt;
    slotNext     = slot;
    addrNext     = ram_addr;
    wdataNext    = ram_wdata;
    weNext       = 1'b0;
    okNext       = 1'b0;
    errNext      = 1'b0;
    codeNext     = err_code;
    npaNext      = new_player_addr;

    unique case (state)
      S_IDLE: begin
        if (enroll_req) begin
          stateNext = S_DIGIT1;
          codeNext  = 2'd0;
        end
      end
      S_DIGIT1: begin
        if (abort) stateNext = S_IDLE;
        else if (digit_btn) begin
          playerIdNext[15:12] = digit_in;
          stateNext           = S_DIGIT2;
        end
      end
      S_DIGIT2: begin
        if (abort) stateNext = S_IDLE;
        else if (digit_btn) begin
          playerIdNext[11:8] = digit_in;
          stateNext          = S_DIGIT3;
        end
      end
      S_DIGIT3: begin
        if (abort) stateNext = S_IDLE;
        else if (digit_btn) begin
          playerIdNext[7:4] = digit_in;
          stateNext         = S_DIGIT4;
        end
      end
      S_DIGIT4: begin
        if (abort) stateNext = S_IDLE;
        else if (digit_btn) begin
          playerIdNext[3:0] = digit_in;
          stateNext         = S_CAPT;
        end
      end
      S_CAPT: begin
        if (playerId == SENTINEL || playerId == GUEST_ID) begin
          stateNext = S_ERROR;
          errNext   = 1'b1;
          codeNext  = 2'd1;
        end else begin
          addrNext  = '0;
          cntNext   = '0;
          stateNext = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == CNT_LAST) stateNext = S_CHECK;
        else cntNext = cnt + CNT_W'(1);
      end
      S_CHECK: begin
        if (ram_rdata == playerId) begin
          stateNext = S_ERROR;
          errNext   = 1'b1;
          codeNext  = 2'd0;
        end else if (ram_rdata == SENTINEL) begin
          if (ram_addr == LAST_ADDR) begin
            stateNext = S_ERROR;
            errNext   = 1'b1;
            codeNext  = 2'd2;
          end else begin
            slotNext  = ram_addr;
            addrNext  = ram_addr + ADDR_W'(1);
            wdataNext = SENTINEL;
            weNext    = 1'b1;
            stateNext = S_WRITE_END;
          end
        end else if (ram_addr == LAST_ADDR) begin
          stateNext = S_ERROR;
          errNext   = 1'b1;
          codeNext  = 2'd3;
        end else begin
          addrNext  = ram_addr + ADDR_W'(1);
          cntNext   = '0;
          stateNext = S_WAIT;
        end
      end
      S_WRITE_END: begin
        addrNext  = slot;
        wdataNext = playerId;
        weNext    = 1'b1;
        stateNext = S_WRITE_ID;
      end
      S_WRITE_ID: begin
`ifdef ENROLL_VERIFY_EN
        addrNext  = slot + ADDR_W'(1);
        cntNext   = '0;
        stateNext = S_VWAIT_END;
`else
        okNext    = 1'b1;
        npaNext   = slot;
        stateNext = S_DONE;
`endif
      end
`ifdef ENROLL_VERIFY_EN
      S_VWAIT_END: begin
        if (cnt == CNT_LAST) stateNext = S_VCHK_END;
        else cntNext = cnt + CNT_W'(1);
      end
      S_VCHK_END: begin
        if (ram_rdata != SENTINEL) begin
          stateNext = S_ERROR;
          errNext   = 1'b1;
          codeNext  = 2'd3;
        end else begin
          addrNext  = slot;
          cntNext   = '0;
          stateNext = S_VWAIT_ID;
        end
      end
      S_VWAIT_ID: begin
        if (cnt == CNT_LAST) stateNext = S_VCHK_ID;
        else cntNext = cnt + CNT_W'(1);
      end
      S_VCHK_ID: begin
        if (ram_rdata != playerId) begin
          stateNext = S_ERROR;
          errNext   = 1'b1;
          codeNext  = 2'd3;
        end else begin
          okNext    = 1'b1;
          npaNext   = slot;
          stateNext = S_DONE;
        end
      end
`endif
      S_DONE:  stateNext = S_IDLE;
      S_ERROR: stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule
